// File: rtl/aes_key_expand_last.sv
// aes_key_expand_last: iterative AES-128 forward key schedule, one round per
// enabled cycle, delivering round key 10 for the decrypt datapath.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   en           global enable; low freezes all state
//   cipher_key   128-bit key, w0 = [127:96] .. w3 = [31:0]
//   key_new_en   start request, sampled when en = 1 and not busy
//   busy         high while the expansion is running
//   key_ready    high while round_key_10 is valid for the current key
//   round_key_10 final round key, same word order as cipher_key
//
// Optional (macro AES_KEY_EXPAND_ROUND_OUT_EN defined):
//   round_key     round key produced on the last expansion edge
//   round_key_vld one-cycle pulse per produced round key
//   round_idx     index 1..10 of round_key

module aes_key_expand_last #(
    parameter int ROUNDS = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [127:0] cipher_key,
    input  logic         key_new_en,
    output logic         busy,
    output logic         key_ready,
    output logic [127:0] round_key_10
`ifdef AES_KEY_EXPAND_ROUND_OUT_EN
    ,
    output logic [127:0] round_key,
    output logic         round_key_vld,
    output logic [3:0]   round_idx
`endif
);

    if (ROUNDS != 10) begin : g_bad_rounds
        $error("aes_key_expand_last: only ROUNDS = 10 is supported");
    end

    localparam logic [3:0] LAST_RC = 4'(ROUNDS - 1);

    // Forward S-box, byte 0x00 in the top 8 bits.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry b sits at bit offset (255 - b) * 8, and 255 - b is ~b.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] r;
        r = ~b;
        return SBOX_TBL[{r, 3'b000} +: 8];
    endfunction

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        DONE
    } state_t;

    state_t       state;
    logic [127:0] wk;
    logic [3:0]   rc;

    logic [7:0]   rcon;
    logic [31:0]  t;
    logic [31:0]  w0n;
    logic [31:0]  w1n;
    logic [31:0]  w2n;
    logic [31:0]  w3n;
    logic [127:0] wk_next;

    // Rcon for the round being produced, i.e. round rc + 1.
    always_comb begin
        rcon = 8'h00;
        case (rc)
            4'd0:    rcon = 8'h01;
            4'd1:    rcon = 8'h02;
            4'd2:    rcon = 8'h04;
            4'd3:    rcon = 8'h08;
            4'd4:    rcon = 8'h10;
            4'd5:    rcon = 8'h20;
            4'd6:    rcon = 8'h40;
            4'd7:    rcon = 8'h80;
            4'd8:    rcon = 8'h1b;
            4'd9:    rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    // SubWord(RotWord(w3)) ^ {rcon, 24'h0}
    assign t = {sbox(wk[23:16]), sbox(wk[15:8]),
                sbox(wk[7:0]),   sbox(wk[31:24])} ^ {rcon, 24'h000000};

    assign w0n = wk[127:96] ^ t;
    assign w1n = wk[95:64]  ^ w0n;
    assign w2n = wk[63:32]  ^ w1n;
    assign w3n = wk[31:0]   ^ w2n;

    assign wk_next = {w0n, w1n, w2n, w3n};

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            wk           <= '0;
            rc           <= '0;
            busy         <= 1'b0;
            key_ready    <= 1'b0;
            round_key_10 <= '0;
`ifdef AES_KEY_EXPAND_ROUND_OUT_EN
            round_key     <= '0;
            round_key_vld <= 1'b0;
            round_idx     <= '0;
`endif
        end else if (en) begin
`ifdef AES_KEY_EXPAND_ROUND_OUT_EN
            round_key_vld <= 1'b0;
`endif
            case (state)
                IDLE, DONE: begin
                    if (key_new_en) begin
                        wk        <= cipher_key;
                        rc        <= '0;
                        busy      <= 1'b1;
                        key_ready <= 1'b0;
                        state     <= EXPAND;
                    end
                end
                EXPAND: begin
                    // New start requests are dropped while expanding.
                    wk <= wk_next;
                    rc <= rc + 4'd1;
`ifdef AES_KEY_EXPAND_ROUND_OUT_EN
                    round_key     <= wk_next;
                    round_idx     <= rc + 4'd1;
                    round_key_vld <= 1'b1;
`endif
                    if (rc == LAST_RC) begin
                        round_key_10 <= wk_next;
                        key_ready    <= 1'b1;
                        busy         <= 1'b0;
                        state        <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end else begin
`ifdef AES_KEY_EXPAND_ROUND_OUT_EN
            // A round key is announced for one cycle only.
            round_key_vld <= 1'b0;
`endif
        end
    end

endmodule
